ecg_display_scheduler: RTL
==========================

// Module: ecg_display_scheduler
// PURPOSE
//  Time-multiplexes the five ECG statistics onto one shared 3-digit 7-segment display.
//  Selects one statistic at a time and converts it from 8-bit binary to BCD with a
//  sequential double-dabble (8 iterations). Holds each statistic for a programmable
//  dwell, then advances. Sits between the statistics counters and the board display pins.
// PARAMETERS
//  DWELL_TICKS  4  tick pulses each statistic is held in HOLD; legal range >= 1
// PORTS
//  clk          in   1  clock
//  reset        in   1  synchronous, active-high reset
//  displaying   in   1  display enable; 0 forces IDLE
//  tick         in   1  1-cycle dwell time-base strobe
//  next         in   1  1-cycle manual advance strobe
//  stat0..stat4 in   8  heart_rate_avg, beats_count, beats_without_violations,
//                       min_threshold_violations, max_threshold_violations
//  stat_sel     out  3  index of the statistic shown (0..4)
//  seg_2/1/0    out  7  hundreds/tens/ones segments {a..g}, active-high
//  busy         out  1  high in LATCH, CONV and LOAD
//  valid        out  1  segments hold a converted value
// BEHAVIOUR
//  Reset: state=IDLE, stat_sel=0, seg_*=7'b0000000, busy=0, valid=0, dwell=0, pending=0.
//  Encoding: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011
//   6=1011111 7=1110000 8=1111111 9=1111011; any other nibble=0000000.
//  IDLE : seg_*=0, valid=0. displaying=1 -> LATCH.
//  LATCH: capture stat[stat_sel] into the shift reg and into a compare copy; clear BCD
//   and iteration count -> CONV.
//  CONV : each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
//   After the 8th iteration -> LOAD.
//  LOAD : register seg_* from BCD; set valid=1; dwell=0 unless this is a refresh -> HOLD.
//  Latency: seg_* update on the 10th rising edge after LATCH is entered.
//  HOLD : tick increments dwell. Advance when (tick and dwell==DWELL_TICKS-1), next=1,
//   or pending=1. Advance sets stat_sel=(stat_sel==4)?0:stat_sel+1, clears pending,
//   and goes to LATCH. Simultaneous tick and next produce a single advance.
//  Refresh: in HOLD with no advance, stat[stat_sel] != compare copy -> LATCH with stat_sel
//   unchanged and dwell preserved.
//  While busy: old seg_* and valid are held. tick is ignored. next sets pending.
//  displaying=0 in any state -> IDLE on the next edge. Any conversion in progress is
//   discarded. stat_sel is kept, pending=0, dwell=0.
//  reset mid-conversion: full reset values on the next edge. Reset has priority over
//   every other input.
//  DWELL_TICKS=1: every tick in HOLD advances.
// CONFIGURATION
//  ECG_DISPLAY_LZB_EN defined: leading-zero blanking.
//   - seg_2=0000000 when the hundreds digit is 0.
//   - seg_1=0000000 when both hundreds and tens are 0.
//   - seg_0 is always shown.
//  ECG_DISPLAY_LZB_EN undefined: all three digits always show their digit code,
//   including leading zeros.
// TESTING
//  1 reset, displaying=1, stat0=137 -> 10 cycles later: seg_2=0110000, seg_1=1111001,
//    seg_0=1110000, stat_sel=0, valid=1, busy=0.
//  2 DWELL_TICKS=4, stat1=255: 4 ticks in HOLD -> stat_sel=1; 10 cycles later:
//    seg_2=1101101, seg_1=1011011, seg_0=1011011.
//  3 five next pulses, each issued in HOLD -> stat_sel goes 1,2,3,4,0. A next during busy
//    is not lost: it advances on the first HOLD cycle.
//  4 displaying->0 during CONV -> next edge: IDLE, seg_*=0, valid=0, busy=0, stat_sel held.
//  5 stat0=7: with LZB_EN -> seg_2=seg_1=0000000, seg_0=1110000; without it ->
//    1111110,1111110,1110000. stat0=0 with LZB_EN -> seg_0=1111110.
//  6 stat0 changes 137->138 in HOLD after 2 ticks -> reconversion, stat_sel=0,
//    seg_0=1111111. Advance occurs after 2 further ticks.

Source files
------------

// File: rtl/ecg_display_if.sv
// Bundles the scheduler's control strobes, statistic inputs and display outputs.
// Combinational bundle only; no storage and no latency of its own.
// No backpressure: strobes are single-cycle pulses, outputs are plain levels.
interface ecg_display_if;
  logic       displaying;
  logic       tick;
  logic       next;
  logic [7:0] stat0;
  logic [7:0] stat1;
  logic [7:0] stat2;
  logic [7:0] stat3;
  logic [7:0] stat4;
  logic [2:0] stat_sel;
  logic [6:0] seg_2;
  logic [6:0] seg_1;
  logic [6:0] seg_0;
  logic       busy;
  logic       valid;

  // Statistics source / board side drives the inputs and watches the display.
  modport master (
    output displaying, tick, next, stat0, stat1, stat2, stat3, stat4,
    input  stat_sel, seg_2, seg_1, seg_0, busy, valid
  );

  // Scheduler side.
  modport slave (
    input  displaying, tick, next, stat0, stat1, stat2, stat3, stat4,
    output stat_sel, seg_2, seg_1, seg_0, busy, valid
  );
endinterface

// File: rtl/ecg_display_scheduler.sv
// Rotates five 8-bit ECG statistics onto one 3-digit 7-segment display via a serial double-dabble.
// Latency: segments update on the 10th clock edge after LATCH is entered (1 latch + 8 shifts + 1 load).
// No backpressure: ticks are dropped while busy, a manual next is remembered and applied in HOLD.
// Optional leading-zero blanking is compiled in with `define ECG_DISPLAY_LZB_EN.
module ecg_display_scheduler #(
  parameter int DWELL_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  ecg_display_if.slave       disp
);

  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CONV,
    S_LOAD,
    S_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     stat_sel_q, stat_sel_d;
  logic [19:0]    shift_q, shift_d;     // {hundreds, tens, ones, binary}
  logic [7:0]     cmp_q, cmp_d;         // value currently on display, for refresh detection
  logic [2:0]     iter_q, iter_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic           pending_q, pending_d; // manual advance requested while busy
  logic           refresh_q, refresh_d; // current conversion is a same-statistic refresh
  logic [6:0]     seg_2_q, seg_2_d;
  logic [6:0]     seg_1_q, seg_1_d;
  logic [6:0]     seg_0_q, seg_0_d;
  logic           valid_q, valid_d;

  logic [7:0]     stat_cur;
  logic [2:0]     sel_adv;
  logic           advance;
  logic [3:0]     dig_h, dig_t, dig_o;
  logic [6:0]     new_seg_2, new_seg_1, new_seg_0;

  // Digit to segment pattern {a..g}; non-decimal nibbles stay dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: correct BCD nibbles >= 5, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  // Select the statistic currently being shown.
  always_comb begin
    stat_cur = disp.stat0;
    case (stat_sel_q)
      3'd0:    stat_cur = disp.stat0;
      3'd1:    stat_cur = disp.stat1;
      3'd2:    stat_cur = disp.stat2;
      3'd3:    stat_cur = disp.stat3;
      3'd4:    stat_cur = disp.stat4;
      default: stat_cur = disp.stat0;
    endcase
  end

  assign sel_adv = (stat_sel_q == 3'd4) ? 3'd0 : stat_sel_q + 3'd1;

  // After the eighth shift the BCD digits sit in the upper twelve bits.
  assign dig_h = shift_q[19:16];
  assign dig_t = shift_q[15:12];
  assign dig_o = shift_q[11:8];

  // Segment patterns for the finished conversion, with optional blanking of leading zeros.
  always_comb begin
    new_seg_2 = seg7(dig_h);
    new_seg_1 = seg7(dig_t);
    new_seg_0 = seg7(dig_o);
`ifdef ECG_DISPLAY_LZB_EN
    if (dig_h == 4'd0) begin
      new_seg_2 = 7'b0000000;
      if (dig_t == 4'd0) new_seg_1 = 7'b0000000;
    end
`else
    new_seg_2 = seg7(dig_h);
`endif
  end

  // Next-state and datapath updates for the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    stat_sel_d = stat_sel_q;
    shift_d    = shift_q;
    cmp_d      = cmp_q;
    iter_d     = iter_q;
    dwell_d    = dwell_q;
    pending_d  = pending_q;
    refresh_d  = refresh_q;
    seg_2_d    = seg_2_q;
    seg_1_d    = seg_1_q;
    seg_0_d    = seg_0_q;
    valid_d    = valid_q;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        seg_2_d   = 7'b0000000;
        seg_1_d   = 7'b0000000;
        seg_0_d   = 7'b0000000;
        valid_d   = 1'b0;
        dwell_d   = '0;
        pending_d = 1'b0;
        refresh_d = 1'b0;
        if (disp.displaying) state_d = S_LATCH;
      end

      S_LATCH: begin
        shift_d = {12'd0, stat_cur};
        cmp_d   = stat_cur;
        iter_d  = 3'd0;
        if (disp.next) pending_d = 1'b1;
        state_d = S_CONV;
      end

      S_CONV: begin
        shift_d = dabble_step(shift_q);
        iter_d  = iter_q + 3'd1;
        if (disp.next) pending_d = 1'b1;
        if (iter_q == 3'd7) state_d = S_LOAD;
      end

      S_LOAD: begin
        seg_2_d = new_seg_2;
        seg_1_d = new_seg_1;
        seg_0_d = new_seg_0;
        valid_d = 1'b1;
        // A refresh keeps the dwell already accumulated for this statistic.
        if (!refresh_q) dwell_d = '0;
        refresh_d = 1'b0;
        if (disp.next) pending_d = 1'b1;
        state_d = S_HOLD;
      end

      S_HOLD: begin
        advance = (disp.tick && (dwell_q == DWELL_LAST)) || disp.next || pending_q;
        if (advance) begin
          stat_sel_d = sel_adv;
          pending_d  = 1'b0;
          refresh_d  = 1'b0;
          state_d    = S_LATCH;
        end else begin
          if (disp.tick) dwell_d = dwell_q + DW'(1);
          if (stat_cur != cmp_q) begin
            refresh_d = 1'b1;
            state_d   = S_LATCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Dropping the enable abandons any conversion but remembers which statistic was shown.
    if (!disp.displaying) begin
      state_d   = S_IDLE;
      seg_2_d   = 7'b0000000;
      seg_1_d   = 7'b0000000;
      seg_0_d   = 7'b0000000;
      valid_d   = 1'b0;
      dwell_d   = '0;
      pending_d = 1'b0;
      refresh_d = 1'b0;
      iter_d    = 3'd0;
    end
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stat_sel_q <= 3'd0;
      shift_q    <= 20'd0;
      cmp_q      <= 8'd0;
      iter_q     <= 3'd0;
      dwell_q    <= '0;
      pending_q  <= 1'b0;
      refresh_q  <= 1'b0;
      seg_2_q    <= 7'b0000000;
      seg_1_q    <= 7'b0000000;
      seg_0_q    <= 7'b0000000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stat_sel_q <= stat_sel_d;
      shift_q    <= shift_d;
      cmp_q      <= cmp_d;
      iter_q     <= iter_d;
      dwell_q    <= dwell_d;
      pending_q  <= pending_d;
      refresh_q  <= refresh_d;
      seg_2_q    <= seg_2_d;
      seg_1_q    <= seg_1_d;
      seg_0_q    <= seg_0_d;
      valid_q    <= valid_d;
    end
  end

  assign disp.stat_sel = stat_sel_q;
  assign disp.seg_2    = seg_2_q;
  assign disp.seg_1    = seg_1_q;
  assign disp.seg_0    = seg_0_q;
  assign disp.valid    = valid_q;
  assign disp.busy     = (state_q == S_LATCH) || (state_q == S_CONV) || (state_q == S_LOAD);

endmodule
